// File: rtl/pe2row_fifo_array_if.sv
// Bundle between the conv PE array, the per-row FIFO array and the row-buffer writer.
// No logic and no latency; it only carries the signals.
// Backpressure uses pe_out_valid/pe_out_ready upstream and a tile-valid/rden stagger downstream.
interface pe2row_fifo_array_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LAST_Wh    = 2,
    parameter int LAST_Iw    = 7,
    parameter int FIFO_DEPTH = 2048,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    // Upstream side (PE array results)
    logic [LAST_Wh-1:0]                                 pe_out_valid;
    logic [LAST_Wh-1:0][LAST_Iw-1:0][DATA_WIDTH-1:0]    pe_out_data;
    logic                                               pe_out_ready;

    // Downstream side (row-buffer writer)
    logic [LAST_Wh-1:0]                                 pe2row_fifo_array1_rden;
    logic                                               pe2row_ready;
    logic [LAST_Wh-1:0][LAST_Iw-1:0][DATA_WIDTH-1:0]    fifo_array1_dataout;
    logic                                               pe2row_data_valid;

    // Status / debug
    logic                                               underflow_err;
    logic [LAST_Wh-1:0][CNT_W-1:0]                      lane_count;

    // FIFO array view
    modport slave (
        input  pe_out_valid,
        input  pe_out_data,
        output pe_out_ready,
        input  pe2row_fifo_array1_rden,
        input  pe2row_ready,
        output fifo_array1_dataout,
        output pe2row_data_valid,
        output underflow_err,
        output lane_count
    );

    // Environment view: drives PE results and the writer's pops
    modport master (
        output pe_out_valid,
        output pe_out_data,
        input  pe_out_ready,
        output pe2row_fifo_array1_rden,
        output pe2row_ready,
        input  fifo_array1_dataout,
        input  pe2row_data_valid,
        input  underflow_err,
        input  lane_count
    );
endinterface

// File: rtl/pe2row_fifo_array.sv
// Per-row elastic buffer: LAST_Wh independent FWFT FIFOs plus a tile-offer FSM for the row writer.
// Latency: a pushed entry reaches dataout one cycle later; a pop is zero-cycle (head captured on the rden edge).
// Backpressure: registered, conservative pe_out_ready; pops on an empty lane are dropped and flagged.
module pe2row_fifo_array #(
    parameter int DATA_WIDTH = 8,
    parameter int LAST_Wh    = 2,
    parameter int LAST_Iw    = 7,
    parameter int TILE_DEPTH = 1024,
    parameter int FIFO_DEPTH = 2048,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    pe2row_fifo_array_if.slave   bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int DCNT_W = $clog2(TILE_DEPTH + 1);
    localparam int LAST   = LAST_Wh - 1;

    typedef logic [LAST_Iw-1:0][DATA_WIDTH-1:0] entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TILE = 2'd1,
        OFFER     = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    // Storage and per-lane bookkeeping
    entry_t                         mem_q [LAST_Wh][FIFO_DEPTH];
    logic [LAST_Wh-1:0][PTR_W-1:0]  wr_ptr_q;
    logic [LAST_Wh-1:0][PTR_W-1:0]  rd_ptr_q;
    logic [LAST_Wh-1:0][CNT_W-1:0]  count_q;
    logic [LAST_Wh-1:0][CNT_W-1:0]  count_d;

    logic [LAST_Wh-1:0]             push;
    logic [LAST_Wh-1:0]             pop;
    logic                           underflow_hit;
    logic                           underflow_q;

    logic                           ready_q;
    logic                           ready_d;
    logic                           tile_full;

    state_t                         state_q;
    logic                           valid_q;
    logic [DCNT_W-1:0]              drain_cnt_q;

    // Per-lane push/pop qualification and next occupancy; empty-lane pops are dropped and flagged
    always_comb begin
        push          = '0;
        pop           = '0;
        underflow_hit = 1'b0;
        count_d       = count_q;
        for (int j = 0; j < LAST_Wh; j++) begin
            push[j] = bus.pe_out_valid[j] & ready_q;
            pop[j]  = bus.pe2row_fifo_array1_rden[j] & (count_q[j] != '0);
            if (bus.pe2row_fifo_array1_rden[j] && (count_q[j] == '0)) begin
                underflow_hit = 1'b1;
            end
            count_d[j] = count_q[j] + CNT_W'(push[j]) - CNT_W'(pop[j]);
        end
    end

    // Next ready looks at post-edge occupancy, so a push accepted in the following cycle always fits.
    // Lanes only accept together, hence the all-lane conditions.
    always_comb begin
        logic all_le;
        logic all_eq;
        all_le = 1'b1;
        all_eq = 1'b1;
        for (int j = 0; j < LAST_Wh; j++) begin
            if (count_d[j] > CNT_W'(FIFO_DEPTH - 2)) begin
                all_le = 1'b0;
            end
            if (count_d[j] != CNT_W'(FIFO_DEPTH - 1)) begin
                all_eq = 1'b0;
            end
        end
        ready_d = all_le | (all_eq & ~(|push));
    end

    // A tile is available once every lane holds at least TILE_DEPTH entries
    always_comb begin
        tile_full = 1'b1;
        for (int j = 0; j < LAST_Wh; j++) begin
            if (count_q[j] < CNT_W'(TILE_DEPTH)) begin
                tile_full = 1'b0;
            end
        end
    end

    // Storage write; contents are meaningless until pointed to, so no reset is needed
    always_ff @(posedge clk) begin
        for (int j = 0; j < LAST_Wh; j++) begin
            if (push[j]) begin
                mem_q[j][wr_ptr_q[j]] <= bus.pe_out_data[j];
            end
        end
    end

    // Pointers wrap naturally (power-of-two depth); counts are kept separately so full/empty is exact
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int j = 0; j < LAST_Wh; j++) begin
                if (push[j]) begin
                    wr_ptr_q[j] <= wr_ptr_q[j] + PTR_W'(1);
                end
                if (pop[j]) begin
                    rd_ptr_q[j] <= rd_ptr_q[j] + PTR_W'(1);
                end
            end
            count_q <= count_d;
        end
    end

    // Registered upstream ready and the sticky underflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            if (underflow_hit) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Tile FSM: offer a full tile, start draining on lane 0's first pop, finish on the last lane's
    // TILE_DEPTH-th pop. Pushes are never blocked by the FSM, so the next tile may fill during DRAIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    state_q <= WAIT_TILE;
                end
                WAIT_TILE: begin
                    if (bus.pe2row_ready && tile_full) begin
                        state_q <= OFFER;
                        valid_q <= 1'b1;
                    end
                end
                OFFER: begin
                    if (bus.pe2row_fifo_array1_rden[0]) begin
                        valid_q <= 1'b0;
                        // Single-lane builds pop the last lane on this very edge
                        if (pop[LAST] && (TILE_DEPTH == 1)) begin
                            state_q     <= WAIT_TILE;
                            drain_cnt_q <= '0;
                        end else begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= pop[LAST] ? DCNT_W'(1) : '0;
                        end
                    end
                end
                DRAIN: begin
                    if (pop[LAST]) begin
                        if (drain_cnt_q == DCNT_W'(TILE_DEPTH - 1)) begin
                            state_q     <= WAIT_TILE;
                            drain_cnt_q <= '0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // First-word-fall-through: each lane always presents its head entry
    always_comb begin
        for (int j = 0; j < LAST_Wh; j++) begin
            bus.fifo_array1_dataout[j] = mem_q[j][rd_ptr_q[j]];
        end
    end

    assign bus.pe_out_ready      = ready_q;
    assign bus.pe2row_data_valid = valid_q;
    assign bus.underflow_err     = underflow_q;
    assign bus.lane_count        = count_q;

endmodule

// File: tb/tb_pe2row_fifo_array.sv
// Directed bench for pe2row_fifo_array with a small configuration (2 lanes, 2 pixels, tile 4, depth 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each comparison is an immediate assertion; failures are counted and reported.
module tb_pe2row_fifo_array;
    localparam int DW = 8;
    localparam int WH = 2;
    localparam int IW = 2;
    localparam int TD = 4;
    localparam int FD = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pe2row_fifo_array_if #(.DATA_WIDTH(DW), .LAST_Wh(WH), .LAST_Iw(IW), .FIFO_DEPTH(FD), .CNT_W(CW)) bus();

    pe2row_fifo_array #(
        .DATA_WIDTH(DW), .LAST_Wh(WH), .LAST_Iw(IW),
        .TILE_DEPTH(TD), .FIFO_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Entry with two distinct pixels so pixel swaps are visible: {pixel1, pixel0}
    function automatic logic [15:0] ent(input logic [7:0] v);
        return {v ^ 8'hA0, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] vld, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [1:0] rd);
        bus.pe_out_valid            = vld;
        bus.pe_out_data[0]          = ent(d0);
        bus.pe_out_data[1]          = ent(d1);
        bus.pe2row_fifo_array1_rden = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rstn             = 1'b0;
        bus.pe2row_ready = 1'b0;
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        tick();
        tick();

        // Reset values
        chk("rst_ready", 32'(bus.pe_out_ready), 0);
        chk("rst_valid", 32'(bus.pe2row_data_valid), 0);
        chk("rst_underflow", 32'(bus.underflow_err), 0);
        chk("rst_count0", 32'(bus.lane_count[0]), 0);
        chk("rst_count1", 32'(bus.lane_count[1]), 0);

        rstn = 1'b1;
        tick();
        chk("ready_after_release", 32'(bus.pe_out_ready), 1);

        // Tile 1: four entries per lane, downstream armed
        bus.pe2row_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(2'b11, 8'(k), 8'(8'h10 + k), 2'b00);
            tick();
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("t1_valid_at_fill", 32'(bus.pe2row_data_valid), 0);
        chk("t1_count0", 32'(bus.lane_count[0]), 4);
        chk("t1_count1", 32'(bus.lane_count[1]), 4);
        chk("t1_head0", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'h00)));
        chk("t1_head1", 32'(bus.fifo_array1_dataout[1]), 32'(ent(8'h10)));
        tick();
        chk("t1_valid_rise", 32'(bus.pe2row_data_valid), 1);

        // Staggered drain: lane 1 one cycle behind lane 0
        for (int i = 0; i < 5; i++) begin
            set_in(2'b00, 8'h00, 8'h00, {(i >= 1), (i < 4)});
            if (i < 4) chk("t1_pop0", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'(i))));
            if (i >= 1) chk("t1_pop1", 32'(bus.fifo_array1_dataout[1]), 32'(ent(8'(8'h10 + i - 1))));
            tick();
            chk("t1_valid_drain", 32'(bus.pe2row_data_valid), 0);
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("t1_end_count0", 32'(bus.lane_count[0]), 0);
        chk("t1_end_count1", 32'(bus.lane_count[1]), 0);
        chk("t1_end_state", 32'(dut.state_q), 1);

        // Simultaneous push and pop on lane 0 at count 3
        bus.pe2row_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(2'b01, 8'(8'h20 + k), 8'h00, 2'b00);
            tick();
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("pp_count_before", 32'(bus.lane_count[0]), 3);
        chk("pp_head_before", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'h20)));
        set_in(2'b01, 8'h23, 8'h00, 2'b01);
        tick();
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("pp_count_after", 32'(bus.lane_count[0]), 3);
        chk("pp_count1_untouched", 32'(bus.lane_count[1]), 0);
        chk("pp_head_after", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'h21)));
        for (int k = 0; k < 3; k++) begin
            set_in(2'b00, 8'h00, 8'h00, 2'b01);
            chk("pp_drain", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'(8'h21 + k))));
            tick();
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("pp_empty", 32'(bus.lane_count[0]), 0);
        chk("pp_no_underflow", 32'(bus.underflow_err), 0);

        // Fill to the top without popping
        for (int k = 0; k < 7; k++) begin
            set_in(2'b11, 8'(8'h30 + k), 8'(8'h40 + k), 2'b00);
            tick();
        end
        set_in(2'b11, 8'h37, 8'h47, 2'b00);
        chk("full_ready_at7", 32'(bus.pe_out_ready), 0);
        chk("full_count_at7", 32'(bus.lane_count[0]), 7);
        tick();
        chk("full_dropped", 32'(bus.lane_count[0]), 7);
        chk("full_ready_reopen", 32'(bus.pe_out_ready), 1);
        tick();
        chk("full_count0_8", 32'(bus.lane_count[0]), 8);
        chk("full_count1_8", 32'(bus.lane_count[1]), 8);
        chk("full_ready_at8", 32'(bus.pe_out_ready), 0);
        set_in(2'b11, 8'hFF, 8'hFF, 2'b00);
        tick();
        tick();
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("full_stays8", 32'(bus.lane_count[0]), 8);
        chk("full_ready_stays0", 32'(bus.pe_out_ready), 0);
        for (int k = 0; k < 8; k++) begin
            set_in(2'b00, 8'h00, 8'h00, 2'b11);
            chk("full_drain0", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'(8'h30 + k))));
            chk("full_drain1", 32'(bus.fifo_array1_dataout[1]), 32'(ent(8'(8'h40 + k))));
            tick();
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("full_end_count0", 32'(bus.lane_count[0]), 0);
        chk("full_end_count1", 32'(bus.lane_count[1]), 0);

        // Underflow on empty lane 1
        set_in(2'b00, 8'h00, 8'h00, 2'b10);
        tick();
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("uf_set", 32'(bus.underflow_err), 1);
        chk("uf_count0", 32'(bus.lane_count[0]), 0);
        chk("uf_count1", 32'(bus.lane_count[1]), 0);
        tick();
        tick();
        chk("uf_sticky", 32'(bus.underflow_err), 1);

        // Tile A offered, tile B pushed while A drains
        bus.pe2row_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(2'b11, 8'(8'h50 + k), 8'(8'h60 + k), 2'b00);
            tick();
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        tick();
        chk("tA_valid", 32'(bus.pe2row_data_valid), 1);
        for (int i = 0; i < 5; i++) begin
            set_in((i < 4) ? 2'b11 : 2'b00, 8'(8'h70 + i), 8'(8'h78 + i), {(i >= 1), (i < 4)});
            if (i < 4) chk("tA_pop0", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'(8'h50 + i))));
            if (i >= 1) chk("tA_pop1", 32'(bus.fifo_array1_dataout[1]), 32'(ent(8'(8'h60 + i - 1))));
            tick();
            chk("tA_valid_held_low", 32'(bus.pe2row_data_valid), 0);
        end
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("tB_count0", 32'(bus.lane_count[0]), 4);
        chk("tB_count1", 32'(bus.lane_count[1]), 4);
        chk("tB_state_wait", 32'(dut.state_q), 1);
        tick();
        chk("tB_valid_rise", 32'(bus.pe2row_data_valid), 1);

        // Start draining tile B, then reset in the middle of DRAIN
        set_in(2'b00, 8'h00, 8'h00, 2'b01);
        chk("tB_head0", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'h70)));
        tick();
        set_in(2'b00, 8'h00, 8'h00, 2'b11);
        chk("tB_head1", 32'(bus.fifo_array1_dataout[1]), 32'(ent(8'h78)));
        tick();
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("tB_state_drain", 32'(dut.state_q), 3);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.pe_out_ready), 0);
        chk("arst_valid", 32'(bus.pe2row_data_valid), 0);
        chk("arst_underflow", 32'(bus.underflow_err), 0);
        chk("arst_count0", 32'(bus.lane_count[0]), 0);
        chk("arst_count1", 32'(bus.lane_count[1]), 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rerst_ready", 32'(bus.pe_out_ready), 1);
        set_in(2'b11, 8'h90, 8'h91, 2'b00);
        tick();
        set_in(2'b00, 8'h00, 8'h00, 2'b00);
        chk("rerst_count0", 32'(bus.lane_count[0]), 1);
        chk("rerst_head0", 32'(bus.fifo_array1_dataout[0]), 32'(ent(8'h90)));
        chk("rerst_head1", 32'(bus.fifo_array1_dataout[1]), 32'(ent(8'h91)));
        chk("rerst_valid", 32'(bus.pe2row_data_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
